// File: rtl/demux_stream.sv
// demux_stream: routes a valid/ready word stream to N one-entry
// channel slots, with broadcast and a saturating illegal-select drop count.
module demux_stream #(
  parameter int WIDTH = 8,
  parameter int N = 4,
  parameter int SELW = $clog2(N),
  parameter int CNTW = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     in_data,
  input  logic [SELW-1:0]      in_sel,
  input  logic                 in_bcast,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [N*WIDTH-1:0]   out_data,
  output logic [N-1:0]         out_valid,
  input  logic [N-1:0]         out_ready,
  output logic [CNTW-1:0]      drop_cnt
);

  logic [N-1:0][WIDTH-1:0] data_q;
  logic [N-1:0] valid_q;
  logic [N-1:0] free;
  logic [N-1:0] hit;
  logic [N-1:0] load;
  logic legal;
  logic xfer;
  logic drop;

  // select decode, slot availability and transfer qualification
  always_comb begin
    hit = '0;
    for (int i = 0; i < N; i++) begin
      hit[i] = (in_sel == SELW'(i));
    end
    free = ~valid_q | out_ready;
    legal = |hit;
    if (in_bcast) begin
      in_ready = &free;
    end else if (legal) begin
      in_ready = |(hit & free);
    end else begin
      in_ready = 1'b1;
    end
    xfer = in_valid && in_ready;
    load = '0;
    if (xfer) begin
      load = in_bcast ? {N{1'b1}} : hit;
    end
    drop = xfer && !in_bcast && !legal;
  end

  // slot registers: reload on transfer, otherwise clear when drained
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (load[i]) begin
          data_q[i]  <= in_data;
          valid_q[i] <= 1'b1;
        end else if (out_ready[i]) begin
          valid_q[i] <= 1'b0;
        end
      end
    end
  end

  // saturating count of words discarded for an out-of-range select
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= '0;
    end else if (drop && (drop_cnt != {CNTW{1'b1}})) begin
      drop_cnt <= drop_cnt + 1'b1;
    end
  end

  assign out_data  = data_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_demux_stream.sv
// tb_demux_stream: directed checks on an N=4 instance and a randomized
// scoreboard run on an N=5 instance with illegal selects and resets.
module tb_demux_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;
  bit done = 1'b0;

  logic        rst_n, a_bcast, a_valid, a_ready;
  logic [7:0]  a_data, a_drop;
  logic [1:0]  a_sel;
  logic [31:0] a_odata;
  logic [3:0]  a_ovalid, a_oready;

  logic        rst5_n, b_bcast, b_valid, b_ready;
  logic [7:0]  b_data, b_drop;
  logic [2:0]  b_sel;
  logic [39:0] b_odata;
  logic [4:0]  b_ovalid, b_oready;

  logic [7:0] q [5][$];
  int exp_drop;

  demux_stream #(.WIDTH(8), .N(4), .CNTW(8)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .in_data(a_data), .in_sel(a_sel),
    .in_bcast(a_bcast), .in_valid(a_valid),
    .in_ready(a_ready), .out_data(a_odata),
    .out_valid(a_ovalid), .out_ready(a_oready),
    .drop_cnt(a_drop)
  );

  demux_stream #(.WIDTH(8), .N(5), .CNTW(8)) dut5 (
    .clk(clk), .rst_n(rst5_n),
    .in_data(b_data), .in_sel(b_sel),
    .in_bcast(b_bcast), .in_valid(b_valid),
    .in_ready(b_ready), .out_data(b_odata),
    .out_valid(b_ovalid), .out_ready(b_oready),
    .drop_cnt(b_drop)
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h, expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic a_send(input logic [7:0] d,
                        input logic [1:0] s,
                        input logic b);
    a_data  = d;
    a_sel   = s;
    a_bcast = b;
    a_valid = 1'b1;
  endtask

  // mode 0 random, 1 illegal burst,
  // 2 reset asserted, 3 reset released
  task automatic b_cycle(input int mode);
    logic [4:0] fr;
    logic er;
    int s;
    @(posedge clk);
    #1;
    if (mode == 2) begin
      rst5_n = 1'b0;
      for (int i = 0; i < 5; i++) q[i].delete();
      exp_drop = 0;
    end
    if (mode == 3) rst5_n = 1'b1;
    b_data   = 8'($urandom);
    b_oready = 5'($urandom) | 5'($urandom);
    if (mode == 1) begin
      b_sel   = 3'd6;
      b_bcast = 1'b0;
      b_valid = 1'b1;
    end else begin
      b_sel   = 3'($urandom_range(0, 7));
      b_bcast = ($urandom_range(0, 7) == 0);
      b_valid = ($urandom_range(0, 3) != 0);
    end
    @(negedge clk);
    #1;
    chk("drop_cnt", b_drop, exp_drop);
    for (int i = 0; i < 5; i++)
      fr[i] = (q[i].size() == 0) || b_oready[i];
    s = int'(b_sel);
    if (b_bcast) er = &fr;
    else if (s < 5) er = fr[s];
    else er = 1'b1;
    chk("in_ready", b_ready, er);
    if (rst5_n && b_valid && er) begin
      if (b_bcast) begin
        for (int i = 0; i < 5; i++)
          q[i].push_back(b_data);
      end else if (s < 5) begin
        q[s].push_back(b_data);
      end else if (exp_drop < 255) begin
        exp_drop++;
      end
    end
  endtask

  // monitor: compare each presented word with the scoreboard
  initial begin
    while (!done) begin
      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
        chk("out_valid", b_ovalid[i], q[i].size() != 0);
        if (b_ovalid[i] && q[i].size() != 0) begin
          chk("out_data", b_odata[i*8 +: 8], q[i][0]);
          if (b_oready[i]) void'(q[i].pop_front());
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; rst5_n = 1'b0;
    a_data = '0; a_sel = '0; a_bcast = 1'b0;
    a_valid = 1'b0; a_oready = 4'hF;
    b_data = '0; b_sel = '0; b_bcast = 1'b0;
    b_valid = 1'b0; b_oready = '0;
    exp_drop = 0;
    step();
    step();
    chk("rst_ovalid", a_ovalid, 0);
    chk("rst_odata", a_odata, 0);
    chk("rst_drop", a_drop, 0);
    chk("rst_ready", a_ready, 1);
    rst_n = 1'b1;
    rst5_n = 1'b1;
    step();

    a_send(8'hA5, 2'd2, 1'b0);
    #1 chk("uni_ready", a_ready, 1);
    step();
    a_valid = 1'b0;
    chk("uni_ovalid", a_ovalid, 4'b0100);
    chk("uni_data", a_odata[23:16], 8'hA5);
    step();
    chk("uni_drain", a_ovalid, 0);

    a_oready = 4'b1101;
    a_send(8'h11, 2'd1, 1'b0);
    step();
    a_send(8'h22, 2'd1, 1'b0);
    #1 chk("bp_ready", a_ready, 0);
    step();
    chk("bp_hold", a_odata[15:8], 8'h11);
    a_send(8'h33, 2'd0, 1'b0);
    #1 chk("bp_other_ready", a_ready, 1);
    step();
    chk("bp_ovalid", a_ovalid, 4'b0011);
    chk("bp_ch0", a_odata[7:0], 8'h33);
    chk("bp_hold2", a_odata[15:8], 8'h11);
    a_send(8'h22, 2'd1, 1'b0);
    a_oready = 4'hF;
    #1 chk("bp_release", a_ready, 1);
    step();
    a_valid = 1'b0;
    chk("bp_next", a_odata[15:8], 8'h22);
    chk("bp_ovalid2", a_ovalid, 4'b0010);
    step();
    chk("bp_empty", a_ovalid, 0);

    a_oready = 4'b0111;
    a_send(8'h77, 2'd3, 1'b0);
    step();
    a_valid = 1'b0;
    chk("bc_fill", a_ovalid, 4'b1000);
    a_send(8'h3C, 2'd0, 1'b1);
    #1 chk("bc_block", a_ready, 0);
    step();
    chk("bc_noload_v", a_ovalid, 4'b1000);
    chk("bc_noload_d", a_odata, 32'h77A52233);
    a_oready = 4'hF;
    #1 chk("bc_ready", a_ready, 1);
    step();
    a_valid = 1'b0;
    a_bcast = 1'b0;
    chk("bc_ovalid", a_ovalid, 4'hF);
    chk("bc_data", a_odata, 32'h3C3C3C3C);
    step();
    chk("bc_drain", a_ovalid, 0);

    for (int k = 1; k <= 16; k++) begin
      a_send(8'(k), 2'd0, 1'b0);
      step();
      chk("st_valid", a_ovalid, 4'b0001);
      chk("st_data", a_odata[7:0], 8'(k));
    end
    a_valid = 1'b0;
    step();
    chk("st_end", a_ovalid, 0);
    for (int k = 1; k <= 8; k++) begin
      a_send(8'(k + 32), 2'd0, 1'b0);
      step();
      chk("st2_data", a_odata[7:0], 8'(k + 32));
    end
    a_send(8'h99, 2'd0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("mrst_ovalid", a_ovalid, 0);
    chk("mrst_odata", a_odata, 0);
    chk("mrst_drop", a_drop, 0);
    chk("mrst_ready", a_ready, 1);
    step();
    chk("mrst_ignore", a_ovalid, 0);
    rst_n = 1'b1;
    a_valid = 1'b0;
    step();
    chk("mrst_after", a_ovalid, 0);

    repeat (600) b_cycle(0);
    repeat (300) b_cycle(1);
    chk("drop_sat", b_drop, 255);
    repeat (200) b_cycle(0);
    b_cycle(2);
    b_cycle(2);
    b_cycle(3);
    repeat (600) b_cycle(0);

    done = 1'b1;
    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, errs);
    $finish;
  end

endmodule
